// File: rtl/rv32m_pkg.sv
// Shared encodings and constants for the RV32M divide unit.
package rv32m_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_t;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] SIGNED_MIN    = 32'h8000_0000;

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract, set quotient bit.
module div_restoring_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // Extra bit keeps the shifted-out MSB so divisors >= 2^(XLEN-1) still work.
    assign shifted  = {rem, quo[XLEN-1]};
    assign trial    = shifted - {1'b0, divisor};
    assign rem_next = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    assign quo_next = {quo[XLEN-2:0], ~trial[XLEN]};

endmodule

// File: rtl/rv32m_div_unit.sv
// Iterative radix-2 DIV/DIVU/REM/REMU unit; one quotient bit per cycle, registered outputs.
module rv32m_div_unit
    import rv32m_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs1_val_i,
    input  logic [XLEN-1:0] rs2_val_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    div_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] rem, quo, dvs;
    logic [4:0]      rd_q;
    logic            is_rem, sign_q, sign_r;

    logic            signed_op, a_neg, b_neg, div_zero, overflow;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN-1:0] step_rem, step_quo, q_fix, r_fix;

    assign signed_op = ~op_i[0];
    assign a_neg     = signed_op & rs1_val_i[XLEN-1];
    assign b_neg     = signed_op & rs2_val_i[XLEN-1];
    assign a_mag     = a_neg ? -rs1_val_i : rs1_val_i;
    assign b_mag     = b_neg ? -rs2_val_i : rs2_val_i;
    assign div_zero  = (rs2_val_i == '0);
    assign overflow  = signed_op && (rs1_val_i == SIGNED_MIN) && (rs2_val_i == DIV_BY_ZERO_Q);

    div_restoring_step #(.XLEN(XLEN)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dvs),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    assign q_fix = sign_q ? -step_quo : step_quo;
    assign r_fix = sign_r ? -step_rem : step_rem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            rd_q     <= '0;
            is_rem   <= 1'b0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            result_o <= '0;
            rd_o     <= '0;
        end else begin
            done_o <= 1'b0;
            if (flush_i) begin
                state  <= IDLE;
                busy_o <= 1'b0;
                cnt    <= '0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start_i) begin
                            rd_q   <= rd_i;
                            is_rem <= op_i[1];
                            sign_q <= a_neg ^ b_neg;
                            sign_r <= a_neg;
                            dvs    <= b_mag;
                            // Special cases complete without iterating.
                            if (div_zero || overflow) begin
                                state  <= DONE;
                                busy_o <= 1'b0;
                                done_o <= 1'b1;
                                cnt    <= '0;
                                rd_o   <= rd_i;
                                if (div_zero)
                                    result_o <= op_i[1] ? rs1_val_i : DIV_BY_ZERO_Q;
                                else
                                    result_o <= op_i[1] ? '0 : SIGNED_MIN;
                            end else begin
                                state  <= CALC;
                                busy_o <= 1'b1;
                                cnt    <= CNT_W'(XLEN);
                                rem    <= '0;
                                quo    <= a_mag;
                            end
                        end else begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end
                    end
                    CALC: begin
                        rem <= step_rem;
                        quo <= step_quo;
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            state    <= DONE;
                            busy_o   <= 1'b0;
                            done_o   <= 1'b1;
                            rd_o     <= rd_q;
                            result_o <= is_rem ? r_fix : q_fix;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rv32m_div_unit.sv
// Directed-vector bench for rv32m_div_unit: arithmetic, special cases, flush, back-to-back, reset.
module tb_rv32m_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] rs1_val_i, rs2_val_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic        busy_o, done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    rv32m_div_unit dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .rs1_val_i(rs1_val_i), .rs2_val_i(rs2_val_i), .rd_i(rd_i),
        .flush_i(flush_i), .busy_o(busy_o), .done_o(done_o),
        .result_o(result_o), .rd_o(rd_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Issue one op at cycle 0 and follow it to done_o (bounded); returns at the negedge of the done cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int lat, output int nbusy,
                          output logic [31:0] res, output logic [4:0] rdo);
        @(posedge clk); #1;
        start_i = 1'b1; op_i = op; rs1_val_i = a; rs2_val_i = b; rd_i = rd;
        @(posedge clk); #1;
        start_i = 1'b0;
        lat = -1; nbusy = 0; res = '0; rdo = '0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (busy_o) nbusy++;
            if (done_o) begin
                lat = c; res = result_o; rdo = rd_o;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; start_i = 1'b0; op_i = '0; rs1_val_i = '0; rs2_val_i = '0;
        rd_i = '0; flush_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({busy_o, done_o, result_o, rd_o} !== 39'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b done=%b result=%h rd=%0d, want all 0",
                     busy_o, done_o, result_o, rd_o);
        end
        rst = 1'b1;
    endtask

    task automatic test_arith;
        logic [1:0]  t_op  [10] = '{2'b00, 2'b10, 2'b00, 2'b11, 2'b01,
                                    2'b00, 2'b10, 2'b10, 2'b01, 2'b11};
        logic [31:0] t_a   [10] = '{32'd100, 32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                    32'd7, 32'd7, 32'hFFFF_FFF9, 32'h8000_0000, 32'd1000};
        logic [31:0] t_b   [10] = '{32'd7, 32'd7, 32'd7, 32'd2, 32'd2,
                                    32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFF, 32'h8000_0001};
        logic [31:0] t_exp [10] = '{32'd14, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 32'd1, 32'h7FFF_FFFF,
                                    32'hFFFF_FFFD, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd1000};
        int lat, nbusy;
        logic [31:0] res;
        logic [4:0] rdo;
        for (int i = 0; i < 10; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], 5'(i + 5), lat, nbusy, res, rdo);
            vectors++;
            if (res !== t_exp[i] || rdo !== 5'(i + 5)) begin
                miscompares++;
                $display("FAIL arith_%0d: got result=%h rd=%0d, want result=%h rd=%0d",
                         i, res, rdo, t_exp[i], i + 5);
            end
            vectors++;
            if (lat != 33 || nbusy != 32) begin
                miscompares++;
                $display("FAIL arith_latency_%0d: got done at %0d busy cycles %0d, want 33 and 32",
                         i, lat, nbusy);
            end
        end
        // Result and tag hold after the pulse; done_o drops.
        @(posedge clk); #1; @(negedge clk);
        vectors++;
        if (done_o !== 1'b0 || result_o !== 32'd1000 || rd_o !== 5'd14) begin
            miscompares++;
            $display("FAIL result_hold: got done=%b result=%h rd=%0d, want done=0 result=000003e8 rd=14",
                     done_o, result_o, rd_o);
        end
    endtask

    task automatic test_special;
        logic [1:0]  t_op  [5] = '{2'b00, 2'b10, 2'b11, 2'b00, 2'b10};
        logic [31:0] t_a   [5] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] t_b   [5] = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] t_exp [5] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd0};
        int lat, nbusy;
        logic [31:0] res;
        logic [4:0] rdo;
        for (int i = 0; i < 5; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], 5'(i + 20), lat, nbusy, res, rdo);
            vectors++;
            if (res !== t_exp[i] || rdo !== 5'(i + 20) || lat != 1 || nbusy != 0) begin
                miscompares++;
                $display("FAIL special_%0d: got result=%h rd=%0d done@%0d busy=%0d, want result=%h rd=%0d done@1 busy=0",
                         i, res, rdo, lat, nbusy, t_exp[i], i + 20);
            end
        end
    endtask

    task automatic test_flush;
        int t0, ndone, done_at;
        logic [31:0] res;
        @(posedge clk); #1;
        t0 = cyc;
        start_i = 1'b1; op_i = 2'b00; rs1_val_i = 32'd50; rs2_val_i = 32'd5; rd_i = 5'd3;
        @(posedge clk); #1;
        start_i = 1'b0;
        while (cyc - t0 < 10) begin @(posedge clk); #1; end
        vectors++;
        if (busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_busy_before: got busy=%b at cycle 10, want 1", busy_o);
        end
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        vectors++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_abort: got busy=%b done=%b at cycle 11, want 0 0", busy_o, done_o);
        end
        @(posedge clk); #1;
        start_i = 1'b1; op_i = 2'b00; rs1_val_i = 32'd9; rs2_val_i = 32'd3; rd_i = 5'd4;
        @(posedge clk); #1;
        start_i = 1'b0;
        ndone = 0; done_at = -1; res = '0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (done_o) begin
                ndone++;
                if (done_at < 0) begin done_at = cyc - t0; res = result_o; end
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (ndone != 1 || done_at != 45 || res !== 32'd3) begin
            miscompares++;
            $display("FAIL flush_restart: got %0d dones first at cycle %0d result=%h, want 1 at 45 result=00000003",
                     ndone, done_at, res);
        end
    endtask

    task automatic test_ignored_start;
        int ndone;
        logic [31:0] res;
        logic [4:0] rdo;
        @(posedge clk); #1;
        start_i = 1'b1; op_i = 2'b00; rs1_val_i = 32'd100; rs2_val_i = 32'd7; rd_i = 5'd5;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        start_i = 1'b1; rs1_val_i = 32'd9; rs2_val_i = 32'd3; rd_i = 5'd9;
        @(posedge clk); #1;
        start_i = 1'b0;
        ndone = 0; res = '0; rdo = '0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (done_o) begin ndone++; res = result_o; rdo = rd_o; end
            @(posedge clk); #1;
        end
        vectors++;
        if (ndone != 1 || res !== 32'd14 || rdo !== 5'd5) begin
            miscompares++;
            $display("FAIL ignored_start: got %0d dones result=%h rd=%0d, want 1 done result=0000000e rd=5",
                     ndone, res, rdo);
        end
    endtask

    task automatic test_back_to_back;
        int lat, nbusy, t1, done_at;
        logic [31:0] res;
        logic [4:0] rdo;
        run_op(2'b00, 32'd100, 32'd7, 5'd5, lat, nbusy, res, rdo);
        // Still in the DONE cycle: present the next start now.
        t1 = cyc;
        start_i = 1'b1; op_i = 2'b01; rs1_val_i = 32'd9; rs2_val_i = 32'd3; rd_i = 5'd7;
        @(posedge clk); #1;
        start_i = 1'b0;
        vectors++;
        if (busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_busy: got busy=%b after start in done cycle, want 1", busy_o);
        end
        done_at = -1; res = '0; rdo = '0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done_o && done_at < 0) begin done_at = cyc - t1; res = result_o; rdo = rd_o; end
            @(posedge clk); #1;
        end
        vectors++;
        if (done_at != 33 || res !== 32'd3 || rdo !== 5'd7) begin
            miscompares++;
            $display("FAIL b2b_done: got done %0d cycles later result=%h rd=%0d, want 33 result=00000003 rd=7",
                     done_at, res, rdo);
        end
    endtask

    task automatic test_mid_reset;
        int t0, ndone;
        @(posedge clk); #1;
        t0 = cyc;
        start_i = 1'b1; op_i = 2'b00; rs1_val_i = 32'd100; rs2_val_i = 32'd7; rd_i = 5'd11;
        @(posedge clk); #1;
        start_i = 1'b0;
        while (cyc - t0 < 15) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        vectors++;
        if ({busy_o, done_o, result_o, rd_o} !== 39'd0) begin
            miscompares++;
            $display("FAIL mid_reset: got busy=%b done=%b result=%h rd=%0d, want all 0",
                     busy_o, done_o, result_o, rd_o);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        ndone = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done_o || busy_o) ndone++;
            @(posedge clk); #1;
        end
        vectors++;
        if (ndone != 0) begin
            miscompares++;
            $display("FAIL mid_reset_quiet: got %0d busy/done cycles after release, want 0", ndone);
        end
    endtask

    initial begin
        test_reset;
        test_arith;
        test_special;
        test_flush;
        test_ignored_start;
        test_back_to_back;
        test_mid_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
